// File: rtl/sort_framer.sv
// sort_framer: collects four upstream bytes into a frame, presents them to an
// external 4-input sorting network, captures the sorted words and streams them
// out one per handshake, smallest first (DESC = 0) or largest first (DESC = 1).
// Fill and drain never overlap: a new frame is accepted only after the previous
// one has fully drained.

module sort_framer #(
  parameter int DESC = 0
) (
  input  logic       clk,
  input  logic       rst,

  // Upstream byte stream
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,

  // External sorting network (srt_out1 <= srt_out2 <= srt_out3 <= srt_out4)
  output logic [7:0] srt_in1,
  output logic [7:0] srt_in2,
  output logic [7:0] srt_in3,
  output logic [7:0] srt_in4,
  input  logic [7:0] srt_out1,
  input  logic [7:0] srt_out2,
  input  logic [7:0] srt_out3,
  input  logic [7:0] srt_out4,

  // Downstream sorted byte stream
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  input  logic       out_ready,

  output logic       frame_done
);

  // FSM encoding
  localparam logic [1:0] ST_FILL    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;

  localparam logic [1:0] LAST_IDX = 2'd3;

  logic [1:0] state_q,    state_d;
  logic [1:0] fill_cnt_q, fill_cnt_d;
  logic [1:0] idx_q,      idx_d;
  logic [7:0] slot_q [4];
  logic [7:0] slot_d [4];
  logic [7:0] res_q  [4];
  logic [7:0] res_d  [4];

  logic       in_accept;
  logic       out_beat;
  logic [1:0] rd_sel;

  // The frame slots feed the sorting network continuously.
  assign srt_in1 = slot_q[0];
  assign srt_in2 = slot_q[1];
  assign srt_in3 = slot_q[2];
  assign srt_in4 = slot_q[3];

  // Handshake and output decode, all derived from registered state so the
  // outputs stay stable while the downstream stalls.
  always_comb begin
    in_ready   = (state_q == ST_FILL);
    in_accept  = in_valid && in_ready;
    out_valid  = (state_q == ST_DRAIN);
    out_beat   = out_valid && out_ready;
    rd_sel     = (DESC != 0) ? (LAST_IDX - idx_q) : idx_q;
    out_data   = out_valid ? res_q[rd_sel] : 8'h00;
    out_last   = out_valid && (idx_q == LAST_IDX);
    frame_done = out_beat && (idx_q == LAST_IDX);
  end

  // Next-state logic: fill slots, capture sorter results, drain one word per
  // handshake and return to fill after the last word.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    idx_d      = idx_q;
    slot_d     = slot_q;
    res_d      = res_q;

    case (state_q)
      ST_FILL: begin
        if (in_accept) begin
          slot_d[fill_cnt_q] = in_data;
          fill_cnt_d         = fill_cnt_q + 2'd1;
          if (fill_cnt_q == LAST_IDX) begin
            state_d = ST_CAPTURE;
          end
        end
      end

      ST_CAPTURE: begin
        // Slots have been stable for a full cycle; the sorter outputs are settled.
        res_d[0]   = srt_out1;
        res_d[1]   = srt_out2;
        res_d[2]   = srt_out3;
        res_d[3]   = srt_out4;
        fill_cnt_d = 2'd0;
        idx_d      = 2'd0;
        state_d    = ST_DRAIN;
      end

      ST_DRAIN: begin
        if (out_beat) begin
          if (idx_q == LAST_IDX) begin
            idx_d      = 2'd0;
            fill_cnt_d = 2'd0;
            state_d    = ST_FILL;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end

      default: begin
        // Unused encoding: recover to an empty frame.
        idx_d      = 2'd0;
        fill_cnt_d = 2'd0;
        state_d    = ST_FILL;
      end
    endcase
  end

  // State registers with asynchronous reset discarding any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the slot and result arrays are reset as well, because their
      // contents are visible on srt_in* and must read zero after reset.
      state_q    <= ST_FILL;
      fill_cnt_q <= 2'd0;
      idx_q      <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        slot_q[i] <= 8'h00;
        res_q[i]  <= 8'h00;
      end
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      idx_q      <= idx_d;
      for (int i = 0; i < 4; i++) begin
        slot_q[i] <= slot_d[i];
        res_q[i]  <= res_d[i];
      end
    end
  end

endmodule

// File: tb/tb_sort_framer.sv
// Directed bench for sort_framer. Two instances share all stimulus: one with
// DESC = 0 (prefix a_) and one with DESC = 1 (prefix d_). Each has its own
// behavioural sorting network. Inputs change 1 time unit after the rising
// edge, and outputs are sampled there too.

module tb_sort_framer;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic       a_in_ready, a_out_valid, a_out_last, a_frame_done;
  logic [7:0] a_out_data;
  logic [7:0] a_srt_in1, a_srt_in2, a_srt_in3, a_srt_in4;
  logic [7:0] a_srt_out1, a_srt_out2, a_srt_out3, a_srt_out4;

  logic       d_in_ready, d_out_valid, d_out_last, d_frame_done;
  logic [7:0] d_out_data;
  logic [7:0] d_srt_in1, d_srt_in2, d_srt_in3, d_srt_in4;
  logic [7:0] d_srt_out1, d_srt_out2, d_srt_out3, d_srt_out4;

  int checks   = 0;
  int failures = 0;

  sort_framer #(.DESC(0)) u_asc (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(a_in_ready),
    .srt_in1(a_srt_in1), .srt_in2(a_srt_in2), .srt_in3(a_srt_in3), .srt_in4(a_srt_in4),
    .srt_out1(a_srt_out1), .srt_out2(a_srt_out2), .srt_out3(a_srt_out3), .srt_out4(a_srt_out4),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_last(a_out_last),
    .out_ready(out_ready), .frame_done(a_frame_done)
  );

  sort_framer #(.DESC(1)) u_desc (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(d_in_ready),
    .srt_in1(d_srt_in1), .srt_in2(d_srt_in2), .srt_in3(d_srt_in3), .srt_in4(d_srt_in4),
    .srt_out1(d_srt_out1), .srt_out2(d_srt_out2), .srt_out3(d_srt_out3), .srt_out4(d_srt_out4),
    .out_valid(d_out_valid), .out_data(d_out_data), .out_last(d_out_last),
    .out_ready(out_ready), .frame_done(d_frame_done)
  );

  // Behavioural 4-input sorting network: returns {max, .., min}.
  function automatic logic [31:0] sort4(input logic [7:0] a, b, c, d);
    logic [7:0] v [4];
    logic [7:0] t;
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    for (int p = 0; p < 3; p++) begin
      for (int j = 0; j < 3 - p; j++) begin
        if (v[j] > v[j+1]) begin
          t = v[j]; v[j] = v[j+1]; v[j+1] = t;
        end
      end
    end
    return {v[3], v[2], v[1], v[0]};
  endfunction

  logic [31:0] a_sorted, d_sorted;
  always_comb a_sorted = sort4(a_srt_in1, a_srt_in2, a_srt_in3, a_srt_in4);
  always_comb d_sorted = sort4(d_srt_in1, d_srt_in2, d_srt_in3, d_srt_in4);
  assign a_srt_out1 = a_sorted[7:0];
  assign a_srt_out2 = a_sorted[15:8];
  assign a_srt_out3 = a_sorted[23:16];
  assign a_srt_out4 = a_sorted[31:24];
  assign d_srt_out1 = d_sorted[7:0];
  assign d_srt_out2 = d_sorted[15:8];
  assign d_srt_out3 = d_sorted[23:16];
  assign d_srt_out4 = d_sorted[31:24];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one byte (in_valid high) and let it be taken on the next edge.
  task automatic push(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    check("a_in_ready_fill", a_in_ready, 1);
    check("d_in_ready_fill", d_in_ready, 1);
    step();
  endtask

  // One downstream word with out_ready high; frame_done expected only on last.
  task automatic beat(input logic [7:0] ea, input logic [7:0] ed, input logic last);
    check("a_out_valid", a_out_valid, 1);
    check("a_out_data",  a_out_data,  ea);
    check("a_out_last",  a_out_last,  last);
    check("a_frame_done", a_frame_done, last);
    check("d_out_valid", d_out_valid, 1);
    check("d_out_data",  d_out_data,  ed);
    check("d_out_last",  d_out_last,  last);
    check("d_frame_done", d_frame_done, last);
    check("a_in_ready_drain", a_in_ready, 0);
    step();
  endtask

  // Check the cycle after the 4th accept (CAPTURE) and step into DRAIN.
  task automatic capture_cycle();
    check("a_out_valid_capture", a_out_valid, 0);
    check("a_in_ready_capture",  a_in_ready,  0);
    check("d_in_ready_capture",  d_in_ready,  0);
    step();
  endtask

  task automatic frame_end();
    check("a_out_valid_after", a_out_valid, 0);
    check("d_out_valid_after", d_out_valid, 0);
    check("a_in_ready_after",  a_in_ready,  1);
    check("a_frame_done_after", a_frame_done, 0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    step();
    step();

    // Reset state
    check("rst_in_ready",   a_in_ready,   1);
    check("rst_out_valid",  a_out_valid,  0);
    check("rst_out_data",   a_out_data,   8'h00);
    check("rst_out_last",   a_out_last,   0);
    check("rst_frame_done", a_frame_done, 0);
    check("rst_srt_in1",    a_srt_in1,    8'h00);
    check("rst_srt_in4",    a_srt_in4,    8'h00);
    check("rst_d_out_valid", d_out_valid, 0);
    rst = 1'b0;
    step();

    // Basic frame, back-to-back bytes
    push(8'h30); push(8'h10); push(8'h40); push(8'h20);
    in_valid = 1'b0;
    check("basic_srt_in1", a_srt_in1, 8'h30);
    check("basic_srt_in2", a_srt_in2, 8'h10);
    check("basic_srt_in3", a_srt_in3, 8'h40);
    check("basic_srt_in4", a_srt_in4, 8'h20);
    capture_cycle();
    beat(8'h10, 8'h40, 1'b0);
    beat(8'h20, 8'h30, 1'b0);
    beat(8'h30, 8'h20, 1'b0);
    beat(8'h40, 8'h10, 1'b1);
    frame_end();

    // Duplicates and extremes
    push(8'hFF); push(8'h00); push(8'hFF); push(8'h00);
    in_valid = 1'b0;
    capture_cycle();
    beat(8'h00, 8'hFF, 1'b0);
    beat(8'h00, 8'hFF, 1'b0);
    beat(8'hFF, 8'h00, 1'b0);
    beat(8'hFF, 8'h00, 1'b1);
    frame_end();

    // Backpressure on the 2nd output; stray input bytes must be refused
    push(8'h0A); push(8'h0D); push(8'h0B); push(8'h0C);
    in_valid = 1'b0;
    capture_cycle();
    beat(8'h0A, 8'h0D, 1'b0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h77;
    for (int k = 0; k < 3; k++) begin
      check("bp_a_out_valid",  a_out_valid,  1);
      check("bp_a_out_data",   a_out_data,   8'h0B);
      check("bp_d_out_data",   d_out_data,   8'h0C);
      check("bp_a_out_last",   a_out_last,   0);
      check("bp_a_frame_done", a_frame_done, 0);
      check("bp_a_in_ready",   a_in_ready,   0);
      step();
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    beat(8'h0B, 8'h0C, 1'b0);
    beat(8'h0C, 8'h0B, 1'b0);
    beat(8'h0D, 8'h0A, 1'b1);
    frame_end();
    check("bp_slot0_kept", a_srt_in1, 8'h0A);

    // Input gaps: valid pattern 1,0,0,1,1,0,1
    in_valid = 1'b1; in_data = 8'h05; step();
    in_valid = 1'b0; in_data = 8'hEE; step();
    in_valid = 1'b0; in_data = 8'hEE; step();
    in_valid = 1'b1; in_data = 8'h01; step();
    in_valid = 1'b1; in_data = 8'h09; step();
    in_valid = 1'b0; in_data = 8'hEE; step();
    in_valid = 1'b1; in_data = 8'h03; step();
    // Keep extra valid pulses asserted through CAPTURE and DRAIN.
    in_data = 8'h55;
    check("gap_srt_in1", a_srt_in1, 8'h05);
    check("gap_srt_in2", a_srt_in2, 8'h01);
    check("gap_srt_in3", a_srt_in3, 8'h09);
    check("gap_srt_in4", a_srt_in4, 8'h03);
    capture_cycle();
    beat(8'h01, 8'h09, 1'b0);
    beat(8'h03, 8'h05, 1'b0);
    beat(8'h05, 8'h03, 1'b0);
    beat(8'h09, 8'h01, 1'b1);
    in_valid = 1'b0;
    frame_end();
    check("gap_slot0_kept", a_srt_in1, 8'h05);
    check("gap_slot3_kept", a_srt_in4, 8'h03);

    // Reset mid-DRAIN after two outputs
    push(8'h60); push(8'h50); push(8'h70); push(8'h80);
    in_valid = 1'b0;
    capture_cycle();
    beat(8'h50, 8'h80, 1'b0);
    beat(8'h60, 8'h70, 1'b0);
    rst = 1'b1;
    #1;
    check("rd_a_out_valid", a_out_valid, 0);
    check("rd_d_out_valid", d_out_valid, 0);
    check("rd_out_data",    a_out_data,  8'h00);
    check("rd_in_ready",    a_in_ready,  1);
    check("rd_srt_in1",     a_srt_in1,   8'h00);
    step();
    rst = 1'b0;
    step();
    check("rd_out_valid_held", a_out_valid, 0);

    // Reset mid-FILL: partial frame discarded
    push(8'h11); push(8'h22);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rf_srt_in1", a_srt_in1, 8'h00);
    check("rf_srt_in2", a_srt_in2, 8'h00);
    step();
    rst = 1'b0;
    step();

    // First frame after reset starts at slot 0
    push(8'h04); push(8'h03); push(8'h02); push(8'h01);
    in_valid = 1'b0;
    check("post_srt_in1", a_srt_in1, 8'h04);
    check("post_srt_in4", a_srt_in4, 8'h01);
    capture_cycle();
    beat(8'h01, 8'h04, 1'b0);
    beat(8'h02, 8'h03, 1'b0);
    beat(8'h03, 8'h02, 1'b0);
    beat(8'h04, 8'h01, 1'b1);
    frame_end();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
